// File: rtl/procyon_lib_pkg.sv
// Shared types and index helpers for the procyon arbitration blocks.
// Index math wraps by compare so requester counts need not be a power of two.
package procyon_lib_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } procyon_arb_state_t;

  // Next index after idx in a ring of n entries.
  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 32'd0 : idx + 32'd1;
  endfunction

  // (a + b) mod n for a, b already in [0, n).
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/procyon_rr_picker.sv
// Combinational round-robin picker: rotate requests so rr_ptr sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module procyon_rr_picker
  import procyon_lib_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   idx_o,
  output logic               any_o
);

  logic [NUM_REQ-1:0] rot;
  logic [PTR_W-1:0]   src;
  logic [PTR_W-1:0]   sel;

  // NOTE: every signal driven here gets a default before any conditional
  // assignment, so no path leaves a value held and no latch is inferred.
  always_comb begin
    rot     = '0;
    src     = '0;
    sel     = '0;
    any_o   = 1'b0;
    grant_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      src    = PTR_W'(wrap_add(32'(i), 32'(rr_ptr_i), NUM_REQ));
      rot[i] = req_i[src];
    end
    // Scan downward so the last hit is the lowest rotated position.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        any_o = 1'b1;
        sel   = PTR_W'(i);
      end
    end
    idx_o = PTR_W'(wrap_add(32'(sel), 32'(rr_ptr_i), NUM_REQ));
    if (any_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/procyon_fifo_wr_arb.sv
// Round-robin burst-aware arbiter sharing one FIFO write port between
// OPTN_NUM_REQ producers; acceptance is combinational in the valid cycle.
module procyon_fifo_wr_arb
  import procyon_lib_pkg::*;
#(
  parameter int OPTN_NUM_REQ    = 4,
  parameter int OPTN_DATA_WIDTH = 8
) (
  input  logic                                         clk,
  input  logic                                         n_rst,
  input  logic                                         i_flush,
  input  logic [OPTN_NUM_REQ-1:0]                      i_req_valid,
  input  logic [OPTN_NUM_REQ-1:0]                      i_req_last,
  input  logic [OPTN_NUM_REQ-1:0][OPTN_DATA_WIDTH-1:0] i_req_data,
  output logic [OPTN_NUM_REQ-1:0]                      o_req_ack,
  output logic                                         o_fifo_we,
  output logic [OPTN_DATA_WIDTH-1:0]                   o_fifo_data,
  input  logic                                         i_fifo_full,
  output logic                                         o_busy
);

  localparam int PTR_W = $clog2(OPTN_NUM_REQ);

  procyon_arb_state_t      state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;

  logic [OPTN_NUM_REQ-1:0] pick_grant;
  logic [PTR_W-1:0]        pick_idx;
  logic                    pick_any;

  logic [OPTN_NUM_REQ-1:0] win_onehot;
  logic [PTR_W-1:0]        win_idx;
  logic                    win_valid;
  logic                    win_last;
  logic                    accept;

  procyon_rr_picker #(
    .NUM_REQ (OPTN_NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_picker (
    .req_i    (i_req_valid),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (pick_grant),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Winner: the picker's choice while idle, only the burst owner while locked.
  always_comb begin
    if (state_q == ARB_LOCKED) begin
      win_idx             = owner_q;
      win_valid           = i_req_valid[owner_q];
      win_onehot          = '0;
      win_onehot[owner_q] = 1'b1;
    end else begin
      win_idx    = pick_idx;
      win_valid  = pick_any;
      win_onehot = pick_grant;
    end
    win_last = i_req_last[win_idx];
    // Reset is folded in so nothing is acked or written while n_rst is low.
    accept   = win_valid & ~i_fifo_full & ~i_flush & n_rst;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    if (i_flush) begin
      state_d = ARB_IDLE;
    end else if (accept) begin
      if (win_last) begin
        state_d  = ARB_IDLE;
        rr_ptr_d = PTR_W'(wrap_inc(32'(win_idx), OPTN_NUM_REQ));
      end else begin
        state_d = ARB_LOCKED;
        owner_d = win_idx;
      end
    end
  end

  always_comb begin
    o_req_ack   = accept ? win_onehot : '0;
    o_fifo_we   = accept;
    o_fifo_data = win_valid ? i_req_data[win_idx] : '0;
    o_busy      = (state_q == ARB_LOCKED);
  end

endmodule

// File: tb/tb_procyon_fifo_wr_arb.sv
// Bench for procyon_fifo_wr_arb: directed scenarios plus random traffic against
// a ring-search reference model, and a separate three-requester instance.
module tb_procyon_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              i_flush;
  logic [NR-1:0]     i_req_valid, i_req_last;
  logic [NR-1:0][DW-1:0] i_req_data;
  logic [NR-1:0]     o_req_ack;
  logic              o_fifo_we;
  logic [DW-1:0]     o_fifo_data;
  logic              i_fifo_full;
  logic              o_busy;

  logic [2:0]        v3, l3, ack3;
  logic [2:0][DW-1:0] d3;
  logic              we3, busy3;
  logic [DW-1:0]     data3;

  int checks   = 0;
  int failures = 0;

  // Reference model state: burst mode, ring pointer, burst owner.
  bit m_locked;
  int m_ptr;
  int m_owner;

  always #5 clk = ~clk;

  procyon_fifo_wr_arb #(.OPTN_NUM_REQ(NR), .OPTN_DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_flush     (i_flush),
    .i_req_valid (i_req_valid),
    .i_req_last  (i_req_last),
    .i_req_data  (i_req_data),
    .o_req_ack   (o_req_ack),
    .o_fifo_we   (o_fifo_we),
    .o_fifo_data (o_fifo_data),
    .i_fifo_full (i_fifo_full),
    .o_busy      (o_busy)
  );

  procyon_fifo_wr_arb #(.OPTN_NUM_REQ(3), .OPTN_DATA_WIDTH(DW)) dut3 (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_flush     (1'b0),
    .i_req_valid (v3),
    .i_req_last  (l3),
    .i_req_data  (d3),
    .o_req_ack   (ack3),
    .o_fifo_we   (we3),
    .o_fifo_data (data3),
    .i_fifo_full (1'b0),
    .o_busy      (busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [NR-1:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < NR; k++) begin
      int j;
      j = (m_ptr + k) % NR;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // One cycle: drive at negedge, compare outputs, advance model at posedge.
  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] l,
                      input logic f, input logic fl, input string tag);
    int   win;
    logic acc;
    i_req_valid = v;
    i_req_last  = l;
    i_fifo_full = f;
    i_flush     = fl;
    i_req_data  = $urandom;
    #1;
    win = model_winner(v);
    acc = (win >= 0) && !f && !fl;
    check({tag, ".ack"}, 32'(o_req_ack), acc ? (32'd1 << win) : 32'd0);
    check({tag, ".we"}, 32'(o_fifo_we), 32'(acc));
    if (acc) check({tag, ".data"}, 32'(o_fifo_data), 32'(i_req_data[win]));
    check({tag, ".busy"}, 32'(o_busy), 32'(m_locked));
    @(posedge clk);
    if (fl) m_locked = 1'b0;
    else if (acc) begin
      if (l[win]) begin
        m_locked = 1'b0;
        m_ptr    = (win + 1) % NR;
      end else begin
        m_locked = 1'b1;
        m_owner  = win;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset with every requester valid: nothing may be acked or written.
    n_rst = 1'b0; i_flush = 1'b0; i_fifo_full = 1'b0;
    i_req_valid = '1; i_req_last = '1; i_req_data = 32'h44332211;
    v3 = '0; l3 = '0; d3 = '0;
    m_locked = 1'b0; m_ptr = 0; m_owner = 0;
    #1;
    check("rst.ack", 32'(o_req_ack), 32'd0);
    check("rst.we", 32'(o_fifo_we), 32'd0);
    check("rst.busy", 32'(o_busy), 32'd0);
    @(negedge clk);
    i_req_valid = '0;
    @(negedge clk);
    n_rst = 1'b1;

    // Four single-beat requesters served in ring order, pointer back at 0.
    for (int i = 0; i < 4; i++) step(4'b1111, 4'b1111, 1'b0, 1'b0, "rr4");
    step(4'b0011, 4'b1111, 1'b0, 1'b0, "rr_wrap");

    // Requester 1 three-beat burst while requester 2 waits.
    step(4'b0110, 4'b0100, 1'b0, 1'b0, "burst1");
    step(4'b0110, 4'b0100, 1'b0, 1'b0, "burst2");
    step(4'b0110, 4'b0110, 1'b0, 1'b0, "burst3");
    step(4'b0100, 4'b0100, 1'b0, 1'b0, "after_burst");

    // Requester 0 locks, bubbles two cycles while requester 3 waits.
    step(4'b0001, 4'b0000, 1'b0, 1'b0, "bub_lock");
    step(4'b1000, 4'b1000, 1'b0, 1'b0, "bubble");
    step(4'b1000, 4'b1000, 1'b0, 1'b0, "bubble");
    step(4'b1001, 4'b1001, 1'b0, 1'b0, "bub_end");
    step(4'b1000, 4'b1000, 1'b0, 1'b0, "bub_next");

    // Requester 2 locked; FIFO full for three cycles.
    step(4'b0100, 4'b0000, 1'b0, 1'b0, "full_lock");
    for (int i = 0; i < 3; i++) step(4'b0100, 4'b0100, 1'b1, 1'b0, "full");
    step(4'b0100, 4'b0100, 1'b0, 1'b0, "full_drop");

    // Flush while requester 1 holds a burst.
    step(4'b0010, 4'b0000, 1'b0, 1'b0, "fl_lock");
    step(4'b0010, 4'b0000, 1'b0, 1'b1, "flush");
    step(4'b1011, 4'b1111, 1'b0, 1'b0, "fl_after");

    // Asynchronous reset in the middle of a burst.
    step(4'b0001, 4'b0000, 1'b0, 1'b0, "mrst_lock");
    i_req_valid = 4'b1111;
    n_rst = 1'b0;
    #1;
    check("mrst.busy", 32'(o_busy), 32'd0);
    check("mrst.ack", 32'(o_req_ack), 32'd0);
    i_req_valid = '0;
    #1;
    n_rst = 1'b1;
    m_locked = 1'b0; m_ptr = 0;
    @(negedge clk);
    step(4'b1010, 4'b1010, 1'b0, 1'b0, "mrst_after");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [NR-1:0] rv, rl;
      rv = NR'($urandom);
      rl = NR'($urandom);
      step(rv, rl, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), "rand");
    end
    i_req_valid = '0;

    // Three-requester build: pointer wraps from 2 to 0, not 3.
    v3 = 3'b100; l3 = 3'b111; d3 = 24'h00ab00;  // requester 2 data 8'h00
    d3[2] = 8'h5a;
    #1;
    check("n3.ack2", 32'(ack3), 32'h4);
    check("n3.data2", 32'(data3), 32'h5a);
    @(negedge clk);
    v3 = 3'b011;
    #1;
    check("n3.wrap", 32'(ack3), 32'h1);
    check("n3.we", 32'(we3), 32'h1);
    @(negedge clk);
    v3 = 3'b101;
    #1;
    check("n3.next", 32'(ack3), 32'h4);
    check("n3.busy", 32'(busy3), 32'h0);
    @(negedge clk);
    v3 = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
